life_generation_engine: RTL and testbench

Streaming Game of Life generation engine with parameterised row width, word width, frame height, horizontal edge mode and Life-like rule masks. It accepts one generation as row-ordered words from the DDR read side and emits the next generation word by word, ready for the DDR write side. It holds three row buffers internally, counts live neighbours per bit and applies configurable birth/survive masks. It also reports the population of each emitted frame.

---
 rtl/life_generation_engine.sv | 190 +++++++++++++++++++
 tb/tb_life_generation_engine.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/life_generation_engine.sv
// Streaming Game of Life generation engine: consumes one frame as row-ordered words,
// emits the next generation word by word, and reports the population of each output frame.
module life_generation_engine #(
  parameter int         COLS    = 640,
  parameter int         WORD    = 16,
  parameter int         ROWS    = 480,
  parameter bit         WRAP    = 1'b1,
  parameter logic [8:0] BIRTH   = 9'h008,
  parameter logic [8:0] SURVIVE = 9'h00C,
  localparam int WORDS = COLS / WORD,
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int WW    = (WORDS > 1) ? $clog2(WORDS) : 1,
  localparam int PW    = $clog2(COLS * ROWS + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            frame_start,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WORD-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WORD-1:0] out_data,
  output logic [RW-1:0]   out_row,
  output logic [WW-1:0]   out_word,
  output logic            frame_done,
  output logic [PW-1:0]   pop_count
);

  typedef enum logic [1:0] {S_LOAD, S_EMIT, S_FLUSH} state_t;

  localparam logic [15:0] BIRTH_M   = 16'(BIRTH);
  localparam logic [15:0] SURVIVE_M = 16'(SURVIVE);

  state_t          state_q, state_d;
  logic            run_q;
  logic [COLS-1:0] a_q, c_q, l_q, l_next;
  logic [WW-1:0]   in_word_q, e_word_q;
  logic [RW-1:0]   in_row_q;
  logic            issued_q;
  logic [PW-1:0]   pop_acc_q;

  logic            accept, row_end_in, emitting, load_en, issue, take, row_done;
  logic [COLS+1:0] above_x, centre_x, below_x;
  logic [WORD+1:0] aw, cw, bw;
  logic [WORD-1:0] next_word;
  logic [3:0]      cnt;
  int              base;

  // Adds the off-edge columns -1 and COLS so every cell sees a full 3-wide window.
  function automatic logic [COLS+1:0] extend(input logic [COLS-1:0] b);
    logic lo, hi;
    lo = WRAP ? b[COLS-1] : 1'b0;
    hi = WRAP ? b[0]      : 1'b0;
    return {hi, b, lo};
  endfunction

  function automatic logic [PW-1:0] popcnt(input logic [WORD-1:0] d);
    logic [PW-1:0] s;
    s = '0;
    for (int i = 0; i < WORD; i++) s = s + PW'(d[i]);
    return s;
  endfunction

  assign in_ready   = run_q && (state_q == S_LOAD);
  assign accept     = in_valid && in_ready;
  assign row_end_in = accept && (in_word_q == WW'(WORDS - 1));
  assign emitting   = (state_q != S_LOAD);
  assign load_en    = !out_valid || out_ready;
  assign issue      = emitting && !issued_q && load_en;
  assign take       = out_valid && out_ready;
  assign row_done   = emitting && take && (out_word == WW'(WORDS - 1));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_LOAD:  if (row_end_in && in_row_q != '0) state_d = S_EMIT;
      S_EMIT:  if (row_done) state_d = (in_row_q == RW'(ROWS - 1)) ? S_FLUSH : S_LOAD;
      S_FLUSH: if (row_done) state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
    if (frame_start) state_d = S_LOAD;
  end

  always_comb begin
    l_next = l_q;
    if (accept) l_next[int'(in_word_q) * WORD +: WORD] = in_data;
  end

  always_comb begin
    above_x   = extend(a_q);
    centre_x  = extend(c_q);
    below_x   = (state_q == S_FLUSH) ? '0 : extend(l_q);
    base      = int'(e_word_q) * WORD;
    aw        = above_x[base +: WORD + 2];
    cw        = centre_x[base +: WORD + 2];
    bw        = below_x[base +: WORD + 2];
    cnt       = '0;
    next_word = '0;
    for (int k = 0; k < WORD; k++) begin
      cnt = 4'(aw[k]) + 4'(aw[k+1]) + 4'(aw[k+2]) + 4'(cw[k]) + 4'(cw[k+2])
          + 4'(bw[k]) + 4'(bw[k+1]) + 4'(bw[k+2]);
      next_word[k] = cw[k+1] ? SURVIVE_M[cnt] : BIRTH_M[cnt];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_LOAD;
    else      state_q <= state_d;
  end

  // NOTE: the row buffers sit in the async reset because a reset must leave no stale cells
  // behind; sequential state uses non-blocking assignments throughout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q      <= 1'b0;
      a_q        <= '0;
      c_q        <= '0;
      l_q        <= '0;
      in_word_q  <= '0;
      e_word_q   <= '0;
      in_row_q   <= '0;
      issued_q   <= 1'b0;
      pop_acc_q  <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_row    <= '0;
      out_word   <= '0;
      frame_done <= 1'b0;
      pop_count  <= '0;
    end else if (frame_start) begin
      run_q      <= 1'b1;
      a_q        <= '0;
      c_q        <= '0;
      l_q        <= '0;
      in_word_q  <= '0;
      e_word_q   <= '0;
      in_row_q   <= '0;
      issued_q   <= 1'b0;
      pop_acc_q  <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      run_q      <= 1'b1;
      frame_done <= 1'b0;

      if (accept) begin
        l_q       <= l_next;
        in_word_q <= (in_word_q == WW'(WORDS - 1)) ? '0 : in_word_q + 1'b1;
      end
      if (row_end_in && in_row_q == '0) begin
        a_q      <= '0;
        c_q      <= l_next;
        in_row_q <= RW'(1);
      end

      if (issue) begin
        out_valid <= 1'b1;
        out_data  <= next_word;
        out_row   <= (state_q == S_FLUSH) ? RW'(ROWS - 1) : in_row_q - 1'b1;
        out_word  <= e_word_q;
        e_word_q  <= (e_word_q == WW'(WORDS - 1)) ? '0 : e_word_q + 1'b1;
        issued_q  <= (e_word_q == WW'(WORDS - 1));
      end else if (take) begin
        out_valid <= 1'b0;
      end

      if (take) pop_acc_q <= pop_acc_q + popcnt(out_data);

      // Row rotation happens on the final take, so the next load starts without a bubble.
      if (row_done) begin
        issued_q <= 1'b0;
        if (state_q == S_FLUSH) begin
          a_q        <= '0;
          c_q        <= '0;
          in_row_q   <= '0;
          frame_done <= 1'b1;
          pop_count  <= pop_acc_q + popcnt(out_data);
          pop_acc_q  <= '0;
        end else begin
          a_q <= c_q;
          c_q <= l_q;
          if (in_row_q != RW'(ROWS - 1)) in_row_q <= in_row_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_life_generation_engine.sv
// Directed bench for life_generation_engine: two instances (WRAP=1 and WRAP=0) share one
// input stream; each output beat is compared with hand-computed next-generation rows.
module tb_life_generation_engine;

  localparam int COLS = 32, WORD = 16, ROWS = 8;
  localparam int BEATS = ROWS * COLS / WORD;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_start = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        out_ready = 1'b1;

  logic        in_ready_w, out_valid_w, frame_done_w;
  logic [15:0] out_data_w;
  logic [2:0]  out_row_w;
  logic [0:0]  out_word_w;
  logic [8:0]  pop_count_w;

  logic        in_ready_n, out_valid_n, frame_done_n;
  logic [15:0] out_data_n;
  logic [2:0]  out_row_n;
  logic [0:0]  out_word_n;
  logic [8:0]  pop_count_n;

  int total = 0;
  int bad   = 0;

  logic [31:0] grid [ROWS];
  logic [31:0] exp_w [ROWS];
  logic [31:0] exp_n [ROWS];

  always #5 clk = ~clk;

  life_generation_engine #(.COLS(COLS), .WORD(WORD), .ROWS(ROWS), .WRAP(1'b1)) dut_w (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .in_valid(in_valid), .in_ready(in_ready_w), .in_data(in_data),
    .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w),
    .out_row(out_row_w), .out_word(out_word_w),
    .frame_done(frame_done_w), .pop_count(pop_count_w)
  );

  life_generation_engine #(.COLS(COLS), .WORD(WORD), .ROWS(ROWS), .WRAP(1'b0)) dut_n (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .in_valid(in_valid), .in_ready(in_ready_n), .in_data(in_data),
    .out_valid(out_valid_n), .out_ready(out_ready), .out_data(out_data_n),
    .out_row(out_row_n), .out_word(out_word_n),
    .frame_done(frame_done_n), .pop_count(pop_count_n)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic clear_grids();
    for (int r = 0; r < ROWS; r++) begin
      grid[r]  = '0;
      exp_w[r] = '0;
      exp_n[r] = '0;
    end
  endtask

  // Streams grid[] into both engines and checks every taken beat in order.
  task automatic run_frame(input string name, input int pop_w, input int pop_n,
                           input int prev_w, input int prev_n, input bit stall, input bit abort);
    int          ptr, idx, cycles, stall_cnt;
    logic [31:0] held, row_v;
    bit          aborted;
    ptr = 0; idx = 0; cycles = 0; stall_cnt = 0; held = '0; aborted = 0;
    @(negedge clk);
    forever begin
      frame_start = 1'b0;
      in_valid    = (ptr < BEATS);
      row_v       = grid[ptr / 2 % ROWS];
      in_data     = row_v[(ptr % 2) * 16 +: 16];
      if (abort && ptr == 9) begin
        frame_start = 1'b1;
        in_valid    = 1'b1;
        aborted     = 1;
      end
      out_ready = 1'b1;
      if (stall && stall_cnt < 5 && out_valid_w && out_row_w == 3'd2 && out_word_w == 1'b0) begin
        out_ready = 1'b0;
        if (stall_cnt == 0) held = {11'd0, out_row_w, out_word_w, out_data_w};
        else check({name, " stall_hold"}, {11'd0, out_row_w, out_word_w, out_data_w}, held);
        stall_cnt++;
      end
      if (aborted) break;
      if (in_valid && in_ready_w) ptr++;
      if (out_valid_w && out_ready) begin
        row_v = exp_w[idx / 2];
        check({name, " order"}, {out_row_w, out_word_w}, 32'(idx));
        check({name, " data_wrap"}, out_data_w, row_v[(idx % 2) * 16 +: 16]);
        row_v = exp_n[idx / 2];
        check({name, " data_nowrap"}, out_data_n, row_v[(idx % 2) * 16 +: 16]);
        if (idx == 0) begin
          check({name, " pop_hold_wrap"}, pop_count_w, prev_w);
          check({name, " pop_hold_nowrap"}, pop_count_n, prev_n);
        end
        idx++;
      end
      if (idx == BEATS) break;
      @(negedge clk);
      cycles++;
      if (cycles > 400) begin
        check({name, " timeout"}, 32'(idx), 32'(BEATS));
        break;
      end
    end
    @(negedge clk);
    frame_start = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    if (aborted) begin
      check({name, " abort_rows_done"}, 32'(idx), 32'd6);
      check({name, " abort_out_valid"}, out_valid_w, 1'b0);
      check({name, " abort_in_ready"}, in_ready_w, 1'b1);
      check({name, " abort_pop_keep"}, pop_count_w, prev_w);
    end else begin
      check({name, " frame_done"}, frame_done_w, 1'b1);
      check({name, " pop_wrap"}, pop_count_w, pop_w);
      check({name, " pop_nowrap"}, pop_count_n, pop_n);
      if (stall) check({name, " stall_seen"}, 32'(stall_cnt), 32'd5);
      @(negedge clk);
      check({name, " frame_done_pulse"}, frame_done_w, 1'b0);
    end
  endtask

  task automatic load_blinker();
    clear_grids();
    grid[3] = 32'h0000_0070;
    for (int r = 2; r <= 4; r++) begin
      exp_w[r] = 32'h0000_0020;
      exp_n[r] = 32'h0000_0020;
    end
  endtask

  task automatic load_block();
    clear_grids();
    grid[6] = 32'h0000_0C00;  grid[7] = 32'h0000_0C00;
    exp_w[6] = 32'h0000_0C00; exp_w[7] = 32'h0000_0C00;
    exp_n[6] = 32'h0000_0C00; exp_n[7] = 32'h0000_0C00;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst in_ready", in_ready_w, 1'b0);
    check("rst out_valid", out_valid_w, 1'b0);
    check("rst out_data", out_data_w, 16'h0);
    check("rst out_row_word", {out_row_w, out_word_w}, 4'h0);
    check("rst frame_done", frame_done_w, 1'b0);
    check("rst pop_count", pop_count_w, 9'd0);
    rst = 1'b1;
    #1 check("rel in_ready_low", in_ready_w, 1'b0);
    @(negedge clk);
    check("rel in_ready_high", in_ready_w, 1'b1);

    load_blinker();
    run_frame("blinker", 3, 3, 0, 0, 1'b0, 1'b0);

    clear_grids();
    grid[3] = 32'h8000_0003;
    for (int r = 2; r <= 4; r++) exp_w[r] = 32'h0000_0001;
    run_frame("wrap", 3, 0, 3, 3, 1'b0, 1'b0);

    load_block();
    run_frame("bottom", 4, 4, 3, 0, 1'b0, 1'b0);

    load_blinker();
    run_frame("stall", 3, 3, 4, 4, 1'b1, 1'b0);

    load_blinker();
    run_frame("abort", 0, 0, 3, 3, 1'b0, 1'b1);

    load_block();
    run_frame("after_abort", 4, 4, 3, 3, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
